store_rmw_unit: RTL and testbench
=================================

Name: store_rmw_unit

Overview:
Store-side counterpart of the load trimmer. The trimmer extracts byte/half/word from a loaded word; this block inserts byte/half/word store data into a 32-bit data memory that has no byte enables.
- Word stores: written directly.
- Byte/half stores: read-modify-write (read old word, merge the lane(s), write back).
- Sits between the core's store path and the data-memory port, with valid/ready on the core side and request/acknowledge on the memory side.

Parameters:
ADDR_W, 32, byte-address width.
TIMEOUT_CYC, 255, maximum cycles to wait for mem_rvalid or mem_wack before aborting with error; 0 disables the timeout.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  store request valid.
req_ready  output  1  block can accept a request (high only in IDLE).
req_addr  input  ADDR_W  byte address.
req_data  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
req_width  input  2  00=byte, 01=half, 10=word, 11=illegal.
mem_addr  output  ADDR_W  word-aligned address: {req_addr[ADDR_W-1:2], 2'b00}.
mem_rd_en  output  1  read request, held until mem_rvalid.
mem_rdata  input  32  read data, valid when mem_rvalid.
mem_rvalid  input  1  read data valid.
mem_wr_en  output  1  write request, held until mem_wack.
mem_wdata  output  32  merged write word.
mem_wack  input  1  write accepted.
done  output  1  one-cycle pulse, store complete.
err  output  1  qualified by done; 1 = store aborted (misalign or timeout).

Behaviour:
- Reset values: req_ready=0 while rst_n=0, then 1 in IDLE; all other outputs 0; state=IDLE; timeout counter=0.
- Reset asserted mid-transaction: the transaction is dropped, no done pulse, and outputs return to reset values immediately (asynchronous).
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1. The request is accepted when req_valid&&req_ready, and addr/data/width are registered.
  - Next state: word → WRITE (mem_wdata=req_data); byte/half → READ; misaligned/illegal → see Optional Feature.
- READ:
  - mem_rd_en=1. On mem_rvalid, merge the lane(s) into mem_rdata, register the result into mem_wdata, and go to WRITE.
  - mem_rvalid is ignored outside READ.
- WRITE: mem_wr_en=1, mem_wdata stable. On mem_wack, go to RESP.
- RESP: done=1 for one cycle, err valid; then IDLE. A new request is accepted no earlier than the cycle after RESP.
- Lane rules:
  - Byte: lane = addr[1:0]; data[7:0] replaces bits [8*lane+7 : 8*lane].
  - Half: addr[1]=0 → bits [15:0], addr[1]=1 → bits [31:16].
  - Unaffected bits come from mem_rdata.
- Latency with zero-wait memory (accept = cycle 0):
  - Word: WRITE in cycle 1, done in cycle 2.
  - Byte/half: READ in cycle 1, WRITE in cycle 2, done in cycle 3.
- Timeout (TIMEOUT_CYC≠0):
  - The counter clears on entry to READ/WRITE and increments each waiting cycle.
  - When it reaches TIMEOUT_CYC, the requests drop and the block goes to RESP with err=1.
  - A READ timeout never issues a write.
- mem_rvalid/mem_wack arriving in the same cycle as the timeout: the handshake wins, with no error.

Optional Feature:
Macro STORE_MISALIGN_TRAP_EN.
- Defined: half with addr[0]=1, word with addr[1:0]≠0, or width=11 → no memory access; IDLE→RESP next cycle with done=1, err=1.
- Undefined: address low bits are truncated (half uses addr[1], word ignores addr[1:0]) and the store proceeds; width=11 is treated as word; err arises only from timeout.

Decomposition:
- Shared package store_pkg:
  - Width codes W_BYTE, W_HALF, W_WORD, W_ILLEGAL.
  - FSM state encoding.
  - Function aligned_addr().
- One natural sub-module: store_lane_merge, combinational (old word, data, width, addr[1:0]) → merged word. It is reusable and unit-testable on its own.

Test Plan:
- Byte, addr 0x103, data 0xAB, mem_rdata 0x11223344 → mem_addr 0x100, mem_wdata 0xAB223344, done at cycle 3, err=0.
- Half, addr 0x102, data 0xBEEF, mem_rdata 0x11223344 → mem_wdata 0xBEEF3344; with mem_rvalid delayed 5 cycles, mem_rd_en is held 5 cycles and done at cycle 8.
- Word, addr 0x200, data 0xDEADBEEF → no mem_rd_en, mem_wdata 0xDEADBEEF, mem_wack in cycle 1, done at cycle 2.
- Half, addr 0x101:
  - With STORE_MISALIGN_TRAP_EN: done+err at cycle 1, no mem_rd_en/mem_wr_en.
  - Without it, old 0x11223344: write 0x1122BEEF, err=0.
- TIMEOUT_CYC=4, byte store with mem_rvalid held 0 → mem_rd_en high 4 cycles, done+err, mem_wr_en never asserted.
- rst_n pulled low in WRITE → mem_wr_en and done drop immediately, req_ready=1 after release, and the next word store completes normally.

Source files
------------

// File: rtl/store_pkg.sv
// ---------------------------------------------------------------------------
// store_pkg
// Shared definitions for the store read-modify-write unit:
//   - width_e  : store width codes carried on req_width
//   - state_e  : FSM state encoding of store_rmw_unit
//   - aligned_addr() : clears the byte offset of a byte address
// ---------------------------------------------------------------------------
package store_pkg;

    typedef enum logic [1:0] {
        W_BYTE    = 2'b00,
        W_HALF    = 2'b01,
        W_WORD    = 2'b10,
        W_ILLEGAL = 2'b11
    } width_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    // Operates on a 64-bit container; callers cast the result down to
    // their own address width.
    function automatic logic [63:0] aligned_addr(input logic [63:0] a);
        return {a[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// ---------------------------------------------------------------------------
// store_lane_merge
// Combinational insertion of right-justified store data into an old
// 32-bit memory word.
//   i_old     : word currently in memory
//   i_data    : store data, right-justified (byte in [7:0], half in [15:0])
//   i_width   : store width code
//   i_addr_lo : byte offset within the word
//   o_merged  : word to write back
// Byte  : lane i_addr_lo replaced.
// Half  : i_addr_lo[1] selects the upper or lower half; i_addr_lo[0] ignored.
// Word / illegal : i_data passes straight through.
// ---------------------------------------------------------------------------
module store_lane_merge
    import store_pkg::*;
(
    input  logic [31:0] i_old,
    input  logic [31:0] i_data,
    input  width_e      i_width,
    input  logic [1:0]  i_addr_lo,
    output logic [31:0] o_merged
);

    always_comb begin
        o_merged = i_old;
        case (i_width)
            W_BYTE: begin
                o_merged[{i_addr_lo, 3'b000} +: 8] = i_data[7:0];
            end
            W_HALF: begin
                if (i_addr_lo[1]) begin
                    o_merged[31:16] = i_data[15:0];
                end else begin
                    o_merged[15:0] = i_data[15:0];
                end
            end
            default: begin
                o_merged = i_data;
            end
        endcase
    end

endmodule

// File: rtl/store_rmw_unit.sv
// ---------------------------------------------------------------------------
// store_rmw_unit
// Inserts byte/half/word store data into a 32-bit data memory without byte
// enables. Word stores are written directly; byte and half stores read the
// old word, merge the lane(s) and write the result back.
//
// Parameters
//   ADDR_W      : byte-address width
//   TIMEOUT_CYC : cycles to wait for mem_rvalid / mem_wack before aborting
//                 with err; 0 disables the timeout
//
// Ports
//   clk, rst_n                    : clock (rising edge), async active-low reset
//   req_valid / req_ready         : core-side handshake (ready only in IDLE)
//   req_addr, req_data, req_width : store request
//   mem_addr                      : word-aligned memory address
//   mem_rd_en / mem_rdata / mem_rvalid : read request, held until mem_rvalid
//   mem_wr_en / mem_wdata / mem_wack   : write request, held until mem_wack
//   done, err                     : one-cycle completion pulse, err qualified
//
// Build option
//   STORE_MISALIGN_TRAP_EN : when defined, a misaligned half/word or an
//   illegal width completes immediately with err=1 and no memory access.
//   When undefined, low address bits are truncated and width 11 acts as word.
// ---------------------------------------------------------------------------
module store_rmw_unit
    import store_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_width,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata,
    input  logic              mem_wack,
    output logic              done,
    output logic              err
);

    // Counter only needs to reach TIMEOUT_CYC-1: the abort fires on the last
    // waiting cycle so the request is held exactly TIMEOUT_CYC cycles.
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    state_e            r_state;
    state_e            w_next;
    logic              r_live;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_lane;
    logic [31:0]       r_data;
    width_e            r_width;
    logic [31:0]       r_wdata;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    width_e            w_req_width;
    logic              w_accept;
    logic              w_waiting;
    logic              w_timeout;
    logic              w_rmw;
    logic [31:0]       w_merged;

    assign w_req_width = width_e'(req_width);
    assign w_accept    = req_valid && r_live && (r_state == ST_IDLE);
    assign w_rmw       = (w_req_width == W_BYTE) || (w_req_width == W_HALF);
    assign w_waiting   = ((r_state == ST_READ)  && !mem_rvalid) ||
                         ((r_state == ST_WRITE) && !mem_wack);
    assign w_timeout   = (TIMEOUT_CYC != 0) && (r_cnt == TO_LAST);

`ifdef STORE_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = ((w_req_width == W_HALF) && req_addr[0]) ||
                        ((w_req_width == W_WORD) && (req_addr[1:0] != 2'b00)) ||
                        (w_req_width == W_ILLEGAL);
`endif

    store_lane_merge u_merge (
        .i_old     (mem_rdata),
        .i_data    (r_data),
        .i_width   (r_width),
        .i_addr_lo (r_lane),
        .o_merged  (w_merged)
    );

    // State register; r_live holds req_ready low until the first clock
    // after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
        end
    end

    // Next state and outputs. A handshake in the same cycle as the timeout
    // takes priority, so the abort branch is only reached without it.
    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = r_live;
                if (w_accept) begin
`ifdef STORE_MISALIGN_TRAP_EN
                    if (w_misalign) begin
                        w_next = ST_RESP;
                    end else begin
                        w_next = w_rmw ? ST_READ : ST_WRITE;
                    end
`else
                    w_next = w_rmw ? ST_READ : ST_WRITE;
`endif
                end
            end
            ST_READ: begin
                mem_rd_en = 1'b1;
                if (mem_rvalid) begin
                    w_next = ST_WRITE;
                end else if (w_timeout) begin
                    w_next = ST_RESP;
                end
            end
            ST_WRITE: begin
                mem_wr_en = 1'b1;
                if (mem_wack || w_timeout) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                done   = 1'b1;
                err    = r_err;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Request capture, merge result and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_lane  <= 2'b00;
            r_data  <= '0;
            r_width <= W_BYTE;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= ADDR_W'(aligned_addr(64'(req_addr)));
                r_lane  <= req_addr[1:0];
                r_data  <= req_data;
                r_width <= w_req_width;
                r_wdata <= req_data;
`ifdef STORE_MISALIGN_TRAP_EN
                r_err   <= w_misalign;
`else
                r_err   <= 1'b0;
`endif
            end else if ((r_state == ST_READ) && mem_rvalid) begin
                r_wdata <= w_merged;
            end else if (w_waiting && w_timeout) begin
                r_err   <= 1'b1;
            end
        end
    end

    // Wait counter: restarts whenever the state changes, counts cycles spent
    // waiting on the memory handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if (w_waiting) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_store_rmw_unit.sv
// ---------------------------------------------------------------------------
// tb_store_rmw_unit
// Directed bench for store_rmw_unit. Instance u_dut uses the default
// timeout; u_dut_to uses TIMEOUT_CYC=4 for the abort case. A small
// responder answers mem_rd_en after rd_delay cycles and mem_wack at once,
// unless blocked.
// ---------------------------------------------------------------------------
module tb_store_rmw_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_width = 2'b00;
    logic [31:0] mem_rdata = 32'h1122_3344;

    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [31:0] a_maddr, b_maddr;
    logic        a_rd_en, b_rd_en, a_rvalid, b_rvalid;
    logic        a_wr_en, b_wr_en, a_wack, b_wack;
    logic [31:0] a_wdata, b_wdata;
    logic        a_done, b_done, a_err, b_err;

    int rd_delay = 0;
    bit rd_block = 1'b0;
    bit wr_block = 1'b0;
    int a_rd_wait = 0, b_rd_wait = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        a_rd_wait <= a_rd_en ? a_rd_wait + 1 : 0;
        b_rd_wait <= b_rd_en ? b_rd_wait + 1 : 0;
    end

    assign a_rvalid = a_rd_en && !rd_block && (a_rd_wait >= rd_delay);
    assign b_rvalid = b_rd_en && !rd_block && (b_rd_wait >= rd_delay);
    assign a_wack   = a_wr_en && !wr_block;
    assign b_wack   = b_wr_en && !wr_block;

    store_rmw_unit u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_valid), .req_ready(a_ready),
        .req_addr(req_addr), .req_data(req_data), .req_width(req_width),
        .mem_addr(a_maddr), .mem_rd_en(a_rd_en), .mem_rdata(mem_rdata),
        .mem_rvalid(a_rvalid), .mem_wr_en(a_wr_en), .mem_wdata(a_wdata),
        .mem_wack(a_wack), .done(a_done), .err(a_err)
    );

    store_rmw_unit #(.TIMEOUT_CYC(4)) u_dut_to (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_valid), .req_ready(b_ready),
        .req_addr(req_addr), .req_data(req_data), .req_width(req_width),
        .mem_addr(b_maddr), .mem_rd_en(b_rd_en), .mem_rdata(mem_rdata),
        .mem_rvalid(b_rvalid), .mem_wr_en(b_wr_en), .mem_wdata(b_wdata),
        .mem_wack(b_wack), .done(b_done), .err(b_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one store on the selected instance (accept edge ends cycle 0)
    // and traces it until done or a 40-cycle budget expires.
    task automatic run_store(input bit sel, input logic [31:0] addr,
                             input logic [31:0] data, input logic [1:0] width,
                             output int done_cyc, output logic err_o,
                             output int rd_cyc, output int rd_wait,
                             output int wr_cyc, output logic [31:0] wdata,
                             output logic [31:0] maddr);
        done_cyc = -1; err_o = 1'bx; rd_cyc = 0; rd_wait = 0; wr_cyc = 0;
        wdata = '0; maddr = '0;
        @(negedge clk);
        req_addr = addr; req_data = data; req_width = width;
        if (sel) b_valid = 1'b1; else a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (sel ? b_rd_en : a_rd_en) begin
                rd_cyc++;
                if (!(sel ? b_rvalid : a_rvalid)) rd_wait++;
            end
            if (sel ? b_wr_en : a_wr_en) begin
                wr_cyc++;
                wdata = sel ? b_wdata : a_wdata;
            end
            if ((sel ? b_rd_en : a_rd_en) || (sel ? b_wr_en : a_wr_en))
                maddr = sel ? b_maddr : a_maddr;
            if (sel ? b_done : a_done) begin
                done_cyc = k;
                err_o = sel ? b_err : a_err;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    int          dc, rc, rw, wc;
    logic        e;
    logic [31:0] wd, ma;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",  {31'd0, a_ready}, 32'd0);
        check("rst_rd_en",  {31'd0, a_rd_en}, 32'd0);
        check("rst_wr_en",  {31'd0, a_wr_en}, 32'd0);
        check("rst_done",   {31'd0, a_done},  32'd0);
        check("rst_err",    {31'd0, a_err},   32'd0);
        check("rst_maddr",  a_maddr, 32'd0);
        check("rst_wdata",  a_wdata, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("idle_ready", {31'd0, a_ready}, 32'd1);

        // Byte, lane 3
        run_store(1'b0, 32'h103, 32'hAB, 2'b00, dc, e, rc, rw, wc, wd, ma);
        check("b3_maddr", ma, 32'h100);
        check("b3_wdata", wd, 32'hAB22_3344);
        check("b3_done",  dc, 32'd3);
        check("b3_err",   {31'd0, e}, 32'd0);
        check("b3_wr",    wc, 32'd1);
        check("ready_after", {31'd0, a_ready}, 32'd1);

        // Byte, lanes 0 and 1; data bits above [7:0] must be dropped
        run_store(1'b0, 32'h4, 32'h1FF, 2'b00, dc, e, rc, rw, wc, wd, ma);
        check("b0_wdata", wd, 32'h1122_33FF);
        check("b0_maddr", ma, 32'h4);
        run_store(1'b0, 32'h5, 32'h5A, 2'b00, dc, e, rc, rw, wc, wd, ma);
        check("b1_wdata", wd, 32'h1122_5A44);

        // Half, upper, read data delayed 5 cycles
        rd_delay = 5;
        run_store(1'b0, 32'h102, 32'hBEEF, 2'b01, dc, e, rc, rw, wc, wd, ma);
        rd_delay = 0;
        check("h2_wdata", wd, 32'hBEEF_3344);
        check("h2_rdwait", rw, 32'd5);
        check("h2_done",  dc, 32'd8);
        check("h2_err",   {31'd0, e}, 32'd0);

        // Word
        run_store(1'b0, 32'h200, 32'hDEAD_BEEF, 2'b10, dc, e, rc, rw, wc, wd, ma);
        check("w_rd",    rc, 32'd0);
        check("w_wdata", wd, 32'hDEAD_BEEF);
        check("w_maddr", ma, 32'h200);
        check("w_done",  dc, 32'd2);
        check("w_err",   {31'd0, e}, 32'd0);

        // Half at odd address
        run_store(1'b0, 32'h101, 32'hBEEF, 2'b01, dc, e, rc, rw, wc, wd, ma);
`ifdef STORE_MISALIGN_TRAP_EN
        check("hm_done", dc, 32'd1);
        check("hm_err",  {31'd0, e}, 32'd1);
        check("hm_rd",   rc, 32'd0);
        check("hm_wr",   wc, 32'd0);
`else
        check("hm_wdata", wd, 32'h1122_BEEF);
        check("hm_err",   {31'd0, e}, 32'd0);
        check("hm_done",  dc, 32'd3);
`endif

        // Read timeout on the TIMEOUT_CYC=4 instance
        rd_block = 1'b1;
        run_store(1'b1, 32'h40, 32'h77, 2'b00, dc, e, rc, rw, wc, wd, ma);
        rd_block = 1'b0;
        check("to_rd",   rc, 32'd4);
        check("to_wr",   wc, 32'd0);
        check("to_done", dc, 32'd5);
        check("to_err",  {31'd0, e}, 32'd1);

        // Reset asserted while in WRITE
        wr_block = 1'b1;
        @(negedge clk);
        req_addr = 32'h300; req_data = 32'h1234_5678; req_width = 2'b10;
        a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        check("rw_wr_en", {31'd0, a_wr_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rw_wr_drop",   {31'd0, a_wr_en}, 32'd0);
        check("rw_done_drop", {31'd0, a_done},  32'd0);
        check("rw_wdata_rst", a_wdata, 32'd0);
        @(negedge clk); rst_n = 1'b1; wr_block = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rw_ready", {31'd0, a_ready}, 32'd1);
        run_store(1'b0, 32'h304, 32'hCAFE_F00D, 2'b10, dc, e, rc, rw, wc, wd, ma);
        check("rw_next_wdata", wd, 32'hCAFE_F00D);
        check("rw_next_done",  dc, 32'd2);
        check("rw_next_err",   {31'd0, e}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
